// File: rtl/bridge_pkg.sv
// Shared constants for the UART-to-memory-bus debug/loader bridge.
// Holds the command/response byte codes and the bridge FSM state encoding.
package bridge_pkg;

   localparam logic [7:0] CMD_WRITE   = 8'h57;
   localparam logic [7:0] CMD_READ    = 8'h52;
   localparam logic [7:0] RSP_OK      = 8'h4B;
   localparam logic [7:0] RSP_TIMEOUT = 8'h54;
   localparam logic [7:0] RSP_ERR     = 8'h3F;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RX_ADDR = 3'd1,
      S_RX_DATA = 3'd2,
      S_RX_GAP  = 3'd3,
      S_BUS     = 3'd4,
      S_TX      = 3'd5,
      S_TX_GAP  = 3'd6
   } state_t;

endpackage

// File: rtl/uart_mem_bridge.sv
// UART-driven bus master: decodes framed W/R host commands, issues one
// 32-bit picorv32-style bus transaction per frame and returns status/data.
// Ports: clk/reset (sync, active-high); rx_data/rx_ready/rx_read from
// uart_rx; tx_data/tx_ready/tx_write to uart_tx; mem_* native bus master;
// active is high whenever the bridge is not idle (CPU hold / bus mux).
module uart_mem_bridge
   import bridge_pkg::*;
#(
   parameter int BUS_TIMEOUT  = 255,
   parameter int BYTE_TIMEOUT = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic        rx_read,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        tx_write,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        active
);

   localparam logic [31:0] BUS_LAST = 32'(BUS_TIMEOUT - 1);
   localparam logic [31:0] BYTE_LIM = 32'(BYTE_TIMEOUT);

   state_t      state_q;
   state_t      gap_next_q;
   logic        is_wr_q;
   logic [1:0]  rx_cnt_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [31:0] tx_buf_q;
   logic [2:0]  tx_cnt_q;
   logic [2:0]  tx_len_q;
   logic [31:0] byte_tmr_q;
   logic [31:0] bus_tmr_q;
   logic        rx_read_q;
   logic [7:0]  tx_data_q;
   logic        tx_write_q;
   logic        mem_valid_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [3:0]  mem_wstrb_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         gap_next_q  <= S_IDLE;
         is_wr_q     <= 1'b0;
         rx_cnt_q    <= 2'd0;
         addr_q      <= 32'h0;
         data_q      <= 32'h0;
         tx_buf_q    <= 32'h0;
         tx_cnt_q    <= 3'd0;
         tx_len_q    <= 3'd0;
         byte_tmr_q  <= 32'h0;
         bus_tmr_q   <= 32'h0;
         rx_read_q   <= 1'b0;
         tx_data_q   <= 8'h0;
         tx_write_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_wstrb_q <= 4'h0;
      end else begin
         rx_read_q  <= 1'b0;
         tx_write_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (rx_ready) begin
                  rx_read_q  <= 1'b1;
                  state_q    <= S_RX_GAP;
                  rx_cnt_q   <= 2'd0;
                  byte_tmr_q <= 32'h0;
                  is_wr_q    <= (rx_data == CMD_WRITE);
                  if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                     gap_next_q <= S_RX_ADDR;
                  end else begin
                     tx_buf_q   <= {24'h0, RSP_ERR};
                     tx_len_q   <= 3'd1;
                     tx_cnt_q   <= 3'd0;
                     gap_next_q <= S_TX;
                  end
               end
            end
            S_RX_ADDR, S_RX_DATA: begin
               if (rx_ready) begin
                  rx_read_q  <= 1'b1;
                  state_q    <= S_RX_GAP;
                  byte_tmr_q <= 32'h0;
                  rx_cnt_q   <= rx_cnt_q + 2'd1;
                  // Little-endian: shift in from the top byte.
                  if (state_q == S_RX_ADDR)
                     addr_q <= {rx_data, addr_q[31:8]};
                  else
                     data_q <= {rx_data, data_q[31:8]};
                  if (rx_cnt_q != 2'd3)
                     gap_next_q <= state_q;
                  else if (state_q == S_RX_ADDR && is_wr_q)
                     gap_next_q <= S_RX_DATA;
                  else
                     gap_next_q <= S_BUS;
               end else if (byte_tmr_q == BYTE_LIM) begin
                  state_q <= S_IDLE;
               end else begin
                  byte_tmr_q <= byte_tmr_q + 32'h1;
               end
            end
            S_RX_GAP: begin
               // Lets the registered rx_ready of uart_rx drop.
               state_q    <= gap_next_q;
               byte_tmr_q <= 32'h0;
            end
            S_BUS: begin
               if (!mem_valid_q) begin
                  mem_valid_q <= 1'b1;
                  mem_addr_q  <= addr_q & 32'hFFFF_FFFC;
                  mem_wdata_q <= is_wr_q ? data_q : 32'h0;
                  mem_wstrb_q <= is_wr_q ? 4'hF : 4'h0;
                  bus_tmr_q   <= 32'h0;
               end else if (mem_ready) begin
                  // Ready wins over a simultaneous timeout.
                  mem_valid_q <= 1'b0;
                  state_q     <= S_TX;
                  tx_cnt_q    <= 3'd0;
                  if (is_wr_q) begin
                     tx_buf_q <= {24'h0, RSP_OK};
                     tx_len_q <= 3'd1;
                  end else begin
                     tx_buf_q <= mem_rdata;
                     tx_len_q <= 3'd4;
                  end
               end else if (bus_tmr_q == BUS_LAST) begin
                  mem_valid_q <= 1'b0;
                  state_q     <= S_TX;
                  tx_cnt_q    <= 3'd0;
                  tx_buf_q    <= {24'h0, RSP_TIMEOUT};
                  tx_len_q    <= 3'd1;
               end else begin
                  bus_tmr_q <= bus_tmr_q + 32'h1;
               end
            end
            S_TX: begin
               if (tx_ready) begin
                  tx_write_q <= 1'b1;
                  tx_data_q  <= tx_buf_q[7:0];
                  tx_buf_q   <= {8'h0, tx_buf_q[31:8]};
                  tx_cnt_q   <= tx_cnt_q + 3'd1;
                  state_q    <= S_TX_GAP;
               end
            end
            S_TX_GAP: begin
               state_q <= (tx_cnt_q == tx_len_q) ? S_IDLE : S_TX;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rx_read   = rx_read_q;
   assign tx_data   = tx_data_q;
   assign tx_write  = tx_write_q;
   assign mem_valid = mem_valid_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign active    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Self-checking bench for uart_mem_bridge: UART byte models, a bus
// responder and a frame-level reference model driving a vector table.
module tb_uart_mem_bridge;

   localparam int BUS_TO  = 255;
   localparam int BYTE_TO = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h0;
   logic        rx_ready = 1'b0;
   logic        rx_read;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic        tx_write;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        active;

   uart_mem_bridge #(
      .BUS_TIMEOUT (BUS_TO),
      .BYTE_TIMEOUT(BYTE_TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .rx_read  (rx_read),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx_write (tx_write),
      .mem_valid(mem_valid),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .active   (active)
   );

   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;

   // uart_rx model: byte FIFO, level rx_ready, drops for a cycle on read.
   logic [7:0] rxmem [0:255];
   int rx_wp = 0;
   int rx_rp = 0;
   int rx_viol = 0;

   always @(negedge clk) begin
      if (rx_read) begin
         if (!rx_ready) rx_viol++;
         rx_rp = rx_rp + 1;
         rx_ready = 1'b0;
      end else if (rx_rp != rx_wp) begin
         rx_ready = 1'b1;
         rx_data = rxmem[rx_rp % 256];
      end else begin
         rx_ready = 1'b0;
      end
   end

   // uart_tx model: collects bytes, random busy periods.
   logic [7:0] txq[$];
   int tx_viol = 0;

   always @(negedge clk) begin
      if (tx_write) begin
         txq.push_back(tx_data);
         if (!tx_ready) tx_viol++;
      end
      tx_ready = ($urandom_range(0, 3) != 0);
   end

   // Bus responder: ready in the rsp_delay-th valid cycle.
   int          rsp_delay = 1;
   logic [31:0] rsp_rdata = 32'h0;
   int          vcnt = 0;
   int          ntrans = 0;
   int          dur = 0;
   bit          stable = 1'b1;
   logic [31:0] cap_addr = 32'h0;
   logic [31:0] cap_wdata = 32'h0;
   logic [3:0]  cap_wstrb = 4'h0;

   always @(negedge clk) begin
      if (mem_valid) begin
         vcnt++;
         if (vcnt == 1) begin
            ntrans++;
            stable = 1'b1;
            cap_addr = mem_addr;
            cap_wdata = mem_wdata;
            cap_wstrb = mem_wstrb;
         end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                      mem_wstrb !== cap_wstrb) begin
            stable = 1'b0;
         end
         dur = vcnt;
         mem_ready = (vcnt == rsp_delay);
         mem_rdata = mem_ready ? rsp_rdata : $urandom;
      end else begin
         vcnt = 0;
         mem_ready = 1'b0;
         mem_rdata = $urandom;
      end
   end

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rdata;
      int          delay;
      logic [31:0] exp_addr;
      logic [31:0] exp_rsp;
      int          exp_len;
      int          exp_dur;
   } vec_t;

   // Frame-level reference: outcome from delay vs timeout only.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      bit ok;
      r = v;
      ok = (v.delay <= BUS_TO);
      r.exp_addr = (v.addr / 4) * 4;
      r.exp_dur = ok ? v.delay : BUS_TO;
      if (!ok) begin
         r.exp_rsp = 32'h54;
         r.exp_len = 1;
      end else if (v.wr) begin
         r.exp_rsp = 32'h4B;
         r.exp_len = 1;
      end else begin
         r.exp_rsp = v.rdata;
         r.exp_len = 4;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      rxmem[rx_wp % 256] = b;
      rx_wp = rx_wp + 1;
   endtask

   task automatic wait_frame(output bit ok);
      int n;
      ok = 1'b1;
      n = 0;
      while (!active && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!active) ok = 1'b0;
      n = 0;
      while (active && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (active) ok = 1'b0;
   endtask

   task automatic run_row(input int idx, input vec_t v);
      int n0;
      int t0;
      bit ok;
      logic [7:0] b;
      n0 = ntrans;
      t0 = txq.size();
      rsp_delay = v.delay;
      rsp_rdata = v.rdata;
      push(v.wr ? 8'h57 : 8'h52);
      for (int k = 0; k < 4; k++) push(v.addr[8*k +: 8]);
      if (v.wr)
         for (int k = 0; k < 4; k++) push(v.data[8*k +: 8]);
      wait_frame(ok);
      chk($sformatf("r%0d_done", idx), 32'(ok), 32'd1);
      chk($sformatf("r%0d_ntx", idx), 32'(txq.size() - t0),
          32'(v.exp_len));
      for (int k = 0; k < v.exp_len; k++) begin
         b = (t0 + k < txq.size()) ? txq[t0 + k] : 8'h00;
         chk($sformatf("r%0d_tx%0d", idx, k), 32'(b),
             32'(v.exp_rsp[8*k +: 8]));
      end
      chk($sformatf("r%0d_ntrans", idx), 32'(ntrans - n0), 32'd1);
      chk($sformatf("r%0d_addr", idx), cap_addr, v.exp_addr);
      chk($sformatf("r%0d_wstrb", idx), 32'(cap_wstrb),
          v.wr ? 32'hF : 32'h0);
      if (v.wr) chk($sformatf("r%0d_wdata", idx), cap_wdata, v.data);
      chk($sformatf("r%0d_dur", idx), 32'(dur), 32'(v.exp_dur));
      chk($sformatf("r%0d_stable", idx), 32'(stable), 32'd1);
   endtask

   vec_t tbl[11];

   initial begin
      int n0;
      int t0;
      int n;
      bit ok;
      logic [7:0] b;
      vec_t v;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rx_read", 32'(rx_read), 32'd0);
      chk("rst_tx_write", 32'(tx_write), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 3,
                 32'h10, 32'h4B, 1, 3};
      tbl[1] = '{1'b0, 32'h10, 32'h0, 32'h12345678, 1,
                 32'h10, 32'h12345678, 4, 1};
      tbl[2] = '{1'b0, 32'h80000020, 32'h0, 32'h0, 1000,
                 32'h80000020, 32'h54, 1, 255};
      tbl[3] = '{1'b1, 32'h3, 32'h1, 32'h0, 255,
                 32'h0, 32'h4B, 1, 255};
      tbl[4] = '{1'b0, 32'h7, 32'h0, 32'hCAFEF00D, 256,
                 32'h4, 32'h54, 1, 255};
      for (int i = 5; i < 11; i++) begin
         v.wr = $urandom_range(0, 1);
         v.addr = $urandom;
         v.data = $urandom;
         v.rdata = $urandom;
         v.delay = $urandom_range(1, 20);
         tbl[i] = model(v);
      end

      for (int i = 0; i < 11; i++) run_row(i, tbl[i]);

      // Unknown command.
      n0 = ntrans;
      t0 = txq.size();
      push(8'h41);
      wait_frame(ok);
      chk("unk_done", 32'(ok), 32'd1);
      chk("unk_ntx", 32'(txq.size() - t0), 32'd1);
      b = (t0 < txq.size()) ? txq[t0] : 8'h00;
      chk("unk_byte", 32'(b), 32'h3F);
      chk("unk_ntrans", 32'(ntrans - n0), 32'd0);

      // Inter-byte timeout.
      n0 = ntrans;
      t0 = txq.size();
      push(8'h57);
      push(8'h01);
      n = 0;
      while (rx_rp != rx_wp && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bto_consumed", 32'(rx_wp - rx_rp), 32'd0);
      repeat (60) @(negedge clk);
      chk("bto_still_active", 32'(active), 32'd1);
      repeat (60) @(negedge clk);
      chk("bto_idle", 32'(active), 32'd0);
      chk("bto_no_tx", 32'(txq.size() - t0), 32'd0);
      chk("bto_no_bus", 32'(ntrans - n0), 32'd0);
      v = '{1'b0, 32'h44, 32'h0, 32'hA5A55A5A, 2, 32'h0, 32'h0, 0, 0};
      run_row(20, model(v));

      // Reset while the bus request is outstanding.
      t0 = txq.size();
      rsp_delay = 1000;
      push(8'h52);
      push(8'h03);
      push(8'h00);
      push(8'h00);
      push(8'h00);
      n = 0;
      while (!mem_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rstbus_valid", 32'(mem_valid), 32'd1);
      chk("rstbus_addr", mem_addr, 32'h0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rstbus_valid_low", 32'(mem_valid), 32'd0);
      chk("rstbus_active_low", 32'(active), 32'd0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("rstbus_no_tx", 32'(txq.size() - t0), 32'd0);
      chk("rstbus_idle", 32'(active), 32'd0);

      chk("tx_ready_respected", 32'(tx_viol), 32'd0);
      chk("rx_read_legal", 32'(rx_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- UART-driven debug/loader master for the native picorv32 memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Sits between the existing uart_rx/uart_tx byte interfaces and the RAM/io address decode, as the initiator side of the bus those blocks answer.
- Host sends framed read/write commands; the block issues single 32-bit bus transactions and returns a status byte or read data.
- `active` lets top hold the CPU and mux the bus during loading.

Parameters:
- BUS_TIMEOUT, 255: max cycles mem_valid stays high without mem_ready before the transaction is aborted.
- BYTE_TIMEOUT, 50000000: max idle cycles between bytes of one command (1 s at 50 MHz) before the frame is discarded.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte; stable while rx_ready is high
- rx_ready  in  1  receive byte available (level)
- rx_read  out  1  one-cycle pulse; consumes the byte
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter idle
- tx_write  out  1  one-cycle pulse; launches tx_data
- mem_valid  out  1  bus request
- mem_addr  out  32  word address; bits [1:0] always 0
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'hF for a write, 4'h0 for a read
- mem_ready  in  1  responder done
- mem_rdata  in  32  read data; valid in the mem_ready cycle
- active  out  1  high whenever state is not IDLE

Behaviour:
- Reset is synchronous, active-high, clock clk. All outputs are 0 after reset. State returns to IDLE and any partial frame or in-flight transaction is dropped; mem_valid is deasserted the cycle after reset is sampled.
- Frame format, all multi-byte fields little-endian:
  - Write: 0x57 'W', addr[4], data[4]. Response: 0x4B 'K', or 0x54 'T' on bus timeout.
  - Read: 0x52 'R', addr[4]. Response: data[4], or a single 0x54 on bus timeout.
  - Any other command byte: respond 0x3F '?' and return to IDLE.
- States:
  - IDLE: wait for a command byte.
  - RX_ADDR, RX_DATA: collect 4 bytes each, using a 2-bit byte counter.
  - BUS: drive the transaction.
  - TX: send the response, using a byte counter over the response length.
  - RX_GAP, TX_GAP: one-cycle guard states.
- Byte receive:
  - In any receiving state, rx_ready=1 causes rx_read to pulse for exactly one cycle and rx_data to be captured in that same cycle.
  - Then one RX_GAP cycle, so the registered rx_ready can clear.
- Inter-byte timeout:
  - A counter runs in RX_ADDR/RX_DATA and clears on each byte.
  - When it reaches BYTE_TIMEOUT, go to IDLE silently with no response.
- Bus transaction:
  - Enter BUS. mem_valid goes high the next cycle, with addr/wdata/wstrb registered and held constant until completion.
  - On the cycle mem_ready=1: capture mem_rdata. Next cycle, mem_valid=0 and the state goes to TX.
  - A cycle counter runs while mem_valid=1. If it reaches BUS_TIMEOUT with no mem_ready, deassert mem_valid and respond 0x54.
  - mem_ready arriving in the same cycle as the timeout counts as success.
  - mem_ready while mem_valid=0 is ignored.
- Transmit:
  - With tx_ready=1, pulse tx_write for one cycle with tx_data valid.
  - Then one TX_GAP cycle before tx_ready is sampled again.
  - After the last byte, return to IDLE.
- Incoming bytes while in BUS or TX are not consumed: rx_read stays 0 and they are left in uart_rx.
- Address bytes [1:0] are received but mem_addr[1:0] is forced to 0.

Decomposition:
- Shared package (bridge_pkg):
  - command/response byte constants (CMD_WRITE, CMD_READ, RSP_OK, RSP_TIMEOUT, RSP_ERR);
  - state encoding localparams.
- No sub-module required. The shift-in/shift-out byte assembler is inline; the two timeout counters are plain registers.

Test Plan:
- Write: bytes 57 10 00 00 00 EF BE AD DE -> mem_valid with addr 0x00000010, wdata 0xDEADBEEF, wstrb F; responder ready after 3 cycles -> tx byte 0x4B; active low afterward.
- Read: bytes 52 10 00 00 00, mem_rdata 0x12345678 with ready -> tx bytes 78 56 34 12 in order, wstrb=0 throughout.
- Unknown byte 0x41 -> single tx 0x3F, no mem_valid.
- Bus timeout: read to 0x80000020 with mem_ready held 0 -> mem_valid high exactly 255 cycles, then tx 0x54.
- Inter-byte timeout (BYTE_TIMEOUT=100 in bench): 57 01 then 101 idle cycles -> IDLE, no tx; a following read frame completes normally.
- Reset during BUS with mem_valid high -> next cycle mem_valid=0, active=0, no tx_write; address bytes 03 00 00 00 -> mem_addr 0x00000000.
